// File: rtl/l2_pmem_line_responder.sv
// -----------------------------------------------------------------------------
// l2_pmem_line_responder
//
// Far (memory) end of the L2 pmem port. It accepts one line read or write at a
// time, serves it from an internal line store after a fixed latency, and
// returns a one-cycle pmem_resp. It is the synthesizable backing store used in
// L2/EWB integration.
//
// Handshake: the requester raises exactly one of pmem_read/pmem_write, with a
// stable pmem_address (and pmem_wdata for writes), and holds them until it
// sees pmem_resp. The request is accepted on the first rising edge in IDLE.
// pmem_resp is high for exactly one cycle. A request still present during
// the RESP cycle is ignored, so the next acceptance happens no earlier than
// the cycle after RESP. Any change to the held request while in WAIT sets the
// sticky proto_err flag. The transaction still completes with the values
// latched at acceptance.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   pmem_read     read request, held until pmem_resp
//   pmem_write    write request, held until pmem_resp
//   pmem_address  line address; offset bits are ignored, bits above the index alias
//   pmem_wdata    write line data
//   pmem_rdata    registered read data, valid in the resp cycle, held until the next read resp
//   pmem_resp     one-cycle completion pulse
//   busy          high in WAIT and RESP
//   proto_err     sticky protocol-violation flag, cleared only by reset
//   dbg_state     current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module l2_pmem_line_responder #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_lidx   = 6,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              busy,
    output logic              proto_err,
    output logic [1:0]        dbg_state
);

    localparam int NLINES = 1 << s_lidx;
    localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                op_wr_q;
    logic [31:0]         addr_q;
    logic [s_line-1:0]   wdata_q;
    logic [NLINES-1:0]   valid_q;
    logic [s_line-1:0]   mem [NLINES];

    logic [s_lidx-1:0]   idx_q, idx_in, rd_idx;
    logic                accept, err_set, load_rd, req_match, mem_we;
    logic [s_line-1:0]   rd_line;

    assign idx_q  = addr_q[s_offset +: s_lidx];
    assign idx_in = pmem_address[s_offset +: s_lidx];

    // Held request must keep the same single operation that was accepted.
    assign req_match = op_wr_q ? (pmem_write && !pmem_read)
                               : (pmem_read && !pmem_write);

    // A line that has never been written reads as all-zero. Its data array
    // entry is never reset.
    assign rd_line = valid_q[rd_idx] ? mem[rd_idx] : '0;

    // The write commits on the RESP edge. A read accepted later sees the new line.
    assign mem_we = (state == RESP) && op_wr_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        err_set = 1'b0;
        load_rd = 1'b0;
        rd_idx  = idx_q;
        case (state)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    err_set = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    accept  = 1'b1;
                    rd_idx  = idx_in;
                    cnt_n   = pmem_write ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
                    // With a latency of 1, the next cycle is already the RESP cycle.
                    if (cnt_n == '0) begin
                        state_n = RESP;
                        load_rd = pmem_read;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 1'b1;
                if (!req_match || (pmem_address != addr_q)) begin
                    err_set = 1'b1;
                end
                if (cnt_n == '0) begin
                    state_n = RESP;
                    load_rd = !op_wr_q;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pmem_rdata <= '0;
            proto_err  <= 1'b0;
            valid_q    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                op_wr_q <= pmem_write;
                addr_q  <= pmem_address;
                wdata_q <= pmem_wdata;
            end
            // Loaded on the edge into RESP, so it is valid during the resp cycle.
            if (load_rd) begin
                pmem_rdata <= rd_line;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (mem_we) begin
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

    // Line data is not reset. The valid bits alone decide what a read returns.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign pmem_resp = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_l2_pmem_line_responder.sv
module tb_l2_pmem_line_responder;

    localparam int LAT = 4;
    localparam logic [255:0] P1 = {8{32'hDEADBEEF}};
    localparam logic [255:0] P2 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] P3 = {16{16'hA55A}};
    localparam logic [255:0] Z  = '0;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp, busy, proto_err;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    l2_pmem_line_responder dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .proto_err    (proto_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [255:0] exp_q[$];
    int           exp_cyc_q[$];
    int           checks   = 0;
    int           errors   = 0;
    int           resp_cnt = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [255:0] mon_exp;
    int           mon_cyc;

    // Monitor: every resp pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst === 1'b1 && pmem_resp === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp at cycle %0d expected none", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("rdata", pmem_rdata, mon_exp);
                check("resp_cycle", 256'(cyc), 256'(mon_cyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drive tasks start just after a rising edge. The current cycle is
    // cycle 0 of the transaction.
    task automatic drive(input bit wr, input logic [31:0] a, input logic [255:0] d);
        pmem_read    = !wr;
        pmem_write   = wr;
        pmem_address = a;
        pmem_wdata   = d;
    endtask

    task automatic expect_resp(input logic [255:0] e);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + LAT);
    endtask

    task automatic drop();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int n   = 0;
        bit got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) got = 1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no resp in 20 cycles expected resp", name);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        drop();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string name, input bit wr, input logic [31:0] a,
                       input logic [255:0] d, input logic [255:0] e);
        drive(wr, a, d);
        expect_resp(e);
        wait_resp(name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drop();
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    // ---------------- stimulus ----------------
    int rc;

    initial begin
        rst          = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        idle(2);
        check("rst_resp",      256'(pmem_resp), 256'(0));
        check("rst_rdata",     pmem_rdata,      Z);
        check("rst_busy",      256'(busy),      256'(0));
        check("rst_proto_err", 256'(proto_err), 256'(0));
        check("rst_state",     256'(dbg_state), 256'(0));
        rst = 1'b1;
        idle(1);

        // Unwritten line reads as zero.
        txn("rd_40", 1'b0, 32'h0000_0040, Z, Z);
        check("err_after_rd40", 256'(proto_err), 256'(0));

        // Write, then read with nonzero offset bits. A write leaves rdata unchanged.
        txn("wr_80", 1'b1, 32'h0000_0080, P1, Z);
        txn("rd_9c", 1'b0, 32'h0000_009C, Z, P1);

        // Alias above the index, and a neighbouring line that was never written.
        txn("wr_100",  1'b1, 32'h0000_0100, P2, P1);
        txn("rd_2100", 1'b0, 32'h0000_2100, Z, P2);
        txn("rd_140",  1'b0, 32'h0000_0140, Z, Z);

        // busy and state during WAIT
        drive(1'b0, 32'h0000_0080, Z);
        expect_resp(P1);
        idle(1);
        check("wait_busy",  256'(busy),      256'(1));
        check("wait_state", 256'(dbg_state), 256'(1));
        wait_resp("rd_80_busy");
        check("idle_busy",   256'(busy),      256'(0));
        check("err_clean",   256'(proto_err), 256'(0));

        // Read and write both high: no acceptance, proto_err set
        rc = resp_cnt;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0080;
        idle(10);
        check("both_no_resp", 256'(resp_cnt),  256'(rc));
        check("both_err",     256'(proto_err), 256'(1));
        check("both_busy",    256'(busy),      256'(0));
        do_reset();
        check("err_cleared", 256'(proto_err), 256'(0));

        // Reset during a write aborts it: no resp and no commit.
        drive(1'b1, 32'h0000_0180, P3);
        idle(2);
        rst = 1'b0;
        drop();
        #1;
        check("abort_busy", 256'(busy), 256'(0));
        idle(1);
        rst = 1'b1;
        rc  = resp_cnt;
        idle(6);
        check("abort_no_resp", 256'(resp_cnt),  256'(rc));
        check("abort_err",     256'(proto_err), 256'(0));
        txn("rd_180_abort", 1'b0, 32'h0000_0180, Z, Z);
        // Reset cleared all valid bits, so earlier writes read back as zero.
        txn("rd_80_after_rst", 1'b0, 32'h0000_0080, Z, Z);

        // Address changed mid-read: latched line is still returned.
        txn("wr_80_again", 1'b1, 32'h0000_0080, P1, Z);
        drive(1'b0, 32'h0000_0080, Z);
        expect_resp(P1);
        idle(2);
        pmem_address = 32'h0000_0100;
        wait_resp("rd_addr_change");
        check("addr_change_err", 256'(proto_err), 256'(1));

        // Back-to-back at minimum spacing: read after write returns the new line.
        txn("wr_3e0", 1'b1, 32'h0000_03E0, P3, P1);
        txn("rd_3e0", 1'b0, 32'h0000_03E0, Z, P3);

        idle(3);
        check("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1);
    end

endmodule
